// File: rtl/handshake_constant_burst.sv
// Elastic constant/stride source: each accepted control token yields BURST data
// tokens starting at CONST_VALUE and advancing by STEP, from a registered output stage.
module handshake_constant_burst #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = '0,
    parameter logic [DATA_WIDTH-1:0] STEP        = '0,
    parameter int unsigned           BURST       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  outs_last
);

    localparam int unsigned      IDX_W    = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic             SINGLE   = (BURST == 1);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             start_burst;

    // Accepting the final beat frees the stage in the same cycle, so a waiting
    // control token can restart the burst without a bubble.
    always_comb begin
        ctrl_ready  = (state == IDLE) || ((state == EMIT) && outs_last && outs_ready);
        start_burst = ctrl_valid && ctrl_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            outs_valid <= 1'b0;
            outs_last  <= 1'b0;
            outs       <= CONST_VALUE;
            idx        <= '0;
        end else if (start_burst) begin
            state      <= EMIT;
            outs_valid <= 1'b1;
            outs       <= CONST_VALUE;
            idx        <= '0;
            outs_last  <= SINGLE;
        end else if ((state == EMIT) && outs_ready) begin
            if (outs_last) begin
                state      <= IDLE;
                outs_valid <= 1'b0;
                outs_last  <= 1'b0;
            end else begin
                idx       <= idx + IDX_ONE;
                outs      <= outs + STEP;
                outs_last <= ((idx + IDX_ONE) == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_handshake_constant_burst.sv
// Bench for handshake_constant_burst: four configurations side by side, each checked
// every cycle against a queue of pending beats derived from the burst arithmetic.
module tb_handshake_constant_burst;

    localparam int unsigned N = 4;
    localparam int unsigned DW [N] = '{30, 8, 8, 16};
    localparam logic [31:0] CVA[N] = '{32'h1C38A23A, 32'h000000FA, 32'h00000005, 32'h00001234};
    localparam logic [31:0] STA[N] = '{32'h0, 32'h3, 32'h1, 32'h0000FFFF};
    localparam int unsigned BLA[N] = '{1, 3, 2, 4};

    logic         clk;
    logic [N-1:0] rst;
    logic [N-1:0] ctrl_valid;
    logic [N-1:0] ctrl_ready;
    logic [N-1:0] outs_valid;
    logic [N-1:0] outs_ready;
    logic [N-1:0] outs_last;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input bit ok, input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < N; g++) begin : inst
        localparam int unsigned W    = DW[g];
        localparam logic [31:0] MASK = (W >= 32) ? 32'hFFFFFFFF : ((32'd1 << W) - 32'd1);
        localparam logic [W-1:0] CVW = W'(CVA[g]);
        localparam logic [W-1:0] STW = W'(STA[g]);

        logic [W-1:0] o;
        logic [32:0]  exp_q[$];
        logic [32:0]  log_q[$];
        bit           started = 1'b0;
        bit           was_rst = 1'b0;

        handshake_constant_burst #(
            .DATA_WIDTH (W),
            .CONST_VALUE(CVW),
            .STEP       (STW),
            .BURST      (BLA[g])
        ) dut (
            .clk       (clk),
            .rst       (rst[g]),
            .ctrl_valid(ctrl_valid[g]),
            .ctrl_ready(ctrl_ready[g]),
            .outs      (o),
            .outs_valid(outs_valid[g]),
            .outs_ready(outs_ready[g]),
            .outs_last (outs_last[g])
        );

        // Inputs are stable from here to the next rising edge, so this process
        // checks the post-edge state and then applies the handshakes of the coming edge.
        always @(negedge clk) begin
            logic        exp_cr;
            logic [32:0] act;
            logic [63:0] v;
            exp_cr = 1'b0;
            act = {outs_last[g], 32'(o)};
            if (started) begin
                exp_cr = (exp_q.size() == 0) || (exp_q.size() == 1 && outs_ready[g]);
                check(outs_valid[g] == (exp_q.size() != 0), $sformatf("valid[%0d]", g),
                      33'(outs_valid[g]), 33'(exp_q.size() != 0));
                if (exp_q.size() != 0)
                    check(act == exp_q[0], $sformatf("beat[%0d]", g), act, exp_q[0]);
                check(ctrl_ready[g] == exp_cr, $sformatf("ctrl_ready[%0d]", g),
                      33'(ctrl_ready[g]), 33'(exp_cr));
                if (was_rst)
                    check(act == {1'b0, 32'(CVW)}, $sformatf("reset_state[%0d]", g), act, {1'b0, 32'(CVW)});
            end
            was_rst = 1'b0;
            if (rst[g]) begin
                exp_q.delete();
                started = 1'b1;
                was_rst = 1'b1;
            end else if (started) begin
                if (outs_valid[g] && outs_ready[g] && exp_q.size() != 0) begin
                    log_q.push_back(act);
                    void'(exp_q.pop_front());
                end
                if (ctrl_valid[g] && exp_cr) begin
                    for (int unsigned i = 0; i < BLA[g]; i++) begin
                        v = 64'(CVA[g]) + 64'(i) * 64'(STA[g]);
                        exp_q.push_back({(i == BLA[g] - 1), v[31:0] & MASK});
                    end
                end
            end
        end
    end

    task automatic rand_phase(input int g, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            ctrl_valid[g] = ($urandom_range(0, 3) != 0);
            outs_ready[g] = ($urandom_range(0, 3) != 0);
            rst[g]        = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst[g] = 1'b0;
        ctrl_valid[g] = 1'b0;
        outs_ready[g] = 1'b1;
        repeat (8) cycle();
    endtask

    initial begin
        rst = '1;
        ctrl_valid = '1;
        outs_ready = '1;
        repeat (3) cycle();
        rst = '0;
        ctrl_valid = '0;
        fork
            begin : br_single
                ctrl_valid[0] = 1'b1;
                repeat (10) cycle();
                ctrl_valid[0] = 1'b0;
                repeat (3) cycle();
                check(inst[0].log_q.size() == 10, "single_count", 33'(inst[0].log_q.size()), 33'd10);
                for (int i = 0; i < 10; i++)
                    check(inst[0].log_q[i] == {1'b1, 32'h1C38A23A}, $sformatf("single_tok%0d", i),
                          inst[0].log_q[i], {1'b1, 32'h1C38A23A});
                rand_phase(0, 3000);
            end
            begin : br_stride
                logic [32:0] seq[6];
                seq = '{{1'b0, 32'hFA}, {1'b0, 32'hFD}, {1'b1, 32'h00},
                        {1'b0, 32'hFA}, {1'b0, 32'hFD}, {1'b1, 32'h00}};
                ctrl_valid[1] = 1'b1;
                cycle();
                ctrl_valid[1] = 1'b0;
                repeat (4) cycle();
                ctrl_valid[1] = 1'b1;
                cycle();
                ctrl_valid[1] = 1'b0;
                cycle();
                outs_ready[1] = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    check(outs_valid[1] && inst[1].o == 8'hFD, $sformatf("stall_hold%0d", i),
                          {outs_valid[1], 32'(inst[1].o)}, {1'b1, 32'hFD});
                    cycle();
                end
                outs_ready[1] = 1'b1;
                repeat (4) cycle();
                check(inst[1].log_q.size() == 6, "stride_count", 33'(inst[1].log_q.size()), 33'd6);
                for (int i = 0; i < 6; i++)
                    check(inst[1].log_q[i] == seq[i], $sformatf("stride_tok%0d", i), inst[1].log_q[i], seq[i]);
                rand_phase(1, 3000);
            end
            begin : br_b2b
                logic [32:0] seq[4];
                seq = '{{1'b0, 32'd5}, {1'b1, 32'd6}, {1'b0, 32'd5}, {1'b1, 32'd6}};
                ctrl_valid[2] = 1'b1;
                repeat (8) cycle();
                ctrl_valid[2] = 1'b0;
                repeat (4) cycle();
                for (int i = 0; i < 4; i++)
                    check(inst[2].log_q[i] == seq[i], $sformatf("b2b_tok%0d", i), inst[2].log_q[i], seq[i]);
                rand_phase(2, 3000);
            end
            begin : br_midrst
                logic [32:0] seq[6];
                seq = '{{1'b0, 32'h1234}, {1'b0, 32'h1233}, {1'b0, 32'h1234},
                        {1'b0, 32'h1233}, {1'b0, 32'h1232}, {1'b1, 32'h1231}};
                ctrl_valid[3] = 1'b1;
                cycle();
                ctrl_valid[3] = 1'b0;
                repeat (2) cycle();
                rst[3] = 1'b1;
                cycle();
                rst[3] = 1'b0;
                ctrl_valid[3] = 1'b1;
                cycle();
                ctrl_valid[3] = 1'b0;
                repeat (6) cycle();
                check(inst[3].log_q.size() == 6, "midrst_count", 33'(inst[3].log_q.size()), 33'd6);
                for (int i = 0; i < 6; i++)
                    check(inst[3].log_q[i] == seq[i], $sformatf("midrst_tok%0d", i), inst[3].log_q[i], seq[i]);
                rand_phase(3, 3000);
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
